// File: rtl/zuzhen_pkg.sv
// Shared definitions for the zuzhen serial link (chaizhen transmitter, zuzhen receiver).
// Latency: none, types and constants only.
// Backpressure: none, types and constants only.
package zuzhen_pkg;

    // Default frame word width of the link.
    localparam int ZZ_WIDTH = 16;

    // Width of the inter-frame gap counter; it covers GAP values 0..255.
    localparam int ZZ_GAP_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } tx_state_t;

endpackage

// File: rtl/chaizhen_shreg.sv
// Parallel-load, shift-right register with a bit counter and a last-bit flag.
// Latency: a loaded word's bit0 is on bit_out one cycle after load; each shift exposes the next bit.
// Backpressure: none; the caller decides when to load or shift.
module chaizhen_shreg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_dat,
    output logic             bit_out,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] shifter;
    logic [CW-1:0]    bit_cnt;

    // Load restarts the bit count; a shift moves the next bit into position 0.
    // Zeros fill from the top, so the register is empty after a full word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shifter <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shifter <= load_dat;
            bit_cnt <= '0;
        end else if (shift) begin
            shifter <= {1'b0, shifter[WIDTH-1:1]};
            bit_cnt <= bit_cnt + CW'(1);
        end
    end

    // bit_out is a flop output, so it is stable for a falling-edge sampler.
    assign bit_out = shifter[0];
    assign last    = (bit_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/chaizhen.sv
// Parallel-to-serial frame transmitter: words in over valid/ready, out LSB first on dout with a frame strobe.
// Latency: a word accepted at edge k drives bit i after edge k+1+i; frame is high after edge k+WIDTH+1.
// Backpressure: din_ready is low while the one-word holding buffer is full; gap-free frames when GAP=0.
module chaizhen
    import zuzhen_pkg::*;
#(
    parameter int WIDTH = ZZ_WIDTH,
    parameter int GAP   = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             frame,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    tx_state_t           state;
    tx_state_t           state_nxt;
    logic [WIDTH-1:0]    hold;
    logic                hold_full;
    logic [ZZ_GAP_W-1:0] gap_cnt;
    logic                gap_done;
    logic                accept;
    logic                sh_last;
    logic                sh_load;
    logic                sh_shift;
    logic                gap_clr;
    logic                gap_inc;
    logic                frame_set;

    // din_ready comes straight from the hold flop; there is no pass-through to the shifter.
    assign din_ready = ~hold_full;
    assign accept    = din_valid & ~hold_full;
    assign gap_done  = (gap_cnt == ZZ_GAP_W'(GAP - 1));
    assign busy      = (state != S_IDLE) | hold_full;

    chaizhen_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk      (clk),
        .reset    (reset),
        .load     (sh_load),
        .shift    (sh_shift),
        .load_dat (hold),
        .bit_out  (dout),
        .last     (sh_last)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: the word end either reloads directly (GAP=0), idles, or enters the gap.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (hold_full) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (sh_last) begin
                    if (GAP > 0)         state_nxt = S_GAP;
                    else if (!hold_full) state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_done) state_nxt = hold_full ? S_SHIFT : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath controls per state. On the last bit the shift still happens, which empties
    // the shifter and so drives dout low, unless a reload takes priority inside the shifter.
    always_comb begin
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        gap_clr   = 1'b0;
        gap_inc   = 1'b0;
        frame_set = 1'b0;
        case (state)
            S_IDLE: begin
                sh_load = hold_full;
            end
            S_SHIFT: begin
                sh_shift = 1'b1;
                if (sh_last) begin
                    frame_set = 1'b1;
                    if (GAP > 0) gap_clr = 1'b1;
                    else         sh_load = hold_full;
                end
            end
            S_GAP: begin
                if (gap_done) sh_load = hold_full;
                else          gap_inc = 1'b1;
            end
            default: ;
        endcase
    end

    // Holding buffer: a reload empties it and an accept fills it; the two never coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (sh_load) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold      <= din;
            hold_full <= 1'b1;
        end
    end

    // Gap counter, which counts idle bit-times after a word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if (gap_clr) begin
            gap_cnt <= '0;
        end else if (gap_inc) begin
            gap_cnt <= gap_cnt + ZZ_GAP_W'(1);
        end
    end

    // Frame strobe and wrapping count of completed words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame     <= 1'b0;
            frame_cnt <= '0;
        end else begin
            frame <= frame_set;
            if (frame_set) frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_chaizhen.sv
// Directed bench for chaizhen, with a behavioural zuzhen receiver on each transmitter.
// Latency: not applicable.
// Backpressure: the bench drives valid and honours din_ready.
module tb_chaizhen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [15:0] din0 = '0;
    logic        vld0 = 1'b0;
    logic        rdy0, dout0, frame0, busy0;
    logic [7:0]  cnt0;

    logic [15:0] din3 = '0;
    logic        vld3 = 1'b0;
    logic        rdy3, dout3, frame3, busy3;
    logic [7:0]  cnt3;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Receiver models: shift dout in at the falling edge and present the word when frame is seen.
    logic [15:0] sr0 = '0;
    logic [15:0] sr3 = '0;
    logic [15:0] rx0[$];
    logic [15:0] rx3[$];
    int          ft0[$];
    int          ft3[$];
    logic [7:0]  cl0[$];
    logic        fd3[$];
    logic        prev_f0 = 1'b0;
    int          dbl0 = 0;

    chaizhen #(.WIDTH(16), .GAP(0), .CNT_W(8)) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .din       (din0),
        .din_valid (vld0),
        .din_ready (rdy0),
        .dout      (dout0),
        .frame     (frame0),
        .busy      (busy0),
        .frame_cnt (cnt0)
    );

    chaizhen #(.WIDTH(16), .GAP(3), .CNT_W(8)) u_dut3 (
        .clk       (clk),
        .reset     (reset),
        .din       (din3),
        .din_valid (vld3),
        .din_ready (rdy3),
        .dout      (dout3),
        .frame     (frame3),
        .busy      (busy3),
        .frame_cnt (cnt3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame0) begin
            rx0.push_back(sr0);
            ft0.push_back(cyc);
            cl0.push_back(cnt0);
            if (prev_f0) dbl0++;
        end
        prev_f0 = frame0;
        sr0 = {dout0, sr0[15:1]};
    end

    always @(negedge clk) begin
        if (frame3) begin
            rx3.push_back(sr3);
            ft3.push_back(cyc);
            fd3.push_back(dout3);
        end
        sr3 = {dout3, sr3[15:1]};
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a word on u_dut0 and return at the falling edge after it was accepted.
    task automatic send0(input logic [15:0] w, output int waited);
        int n;
        n = 0;
        din0 = w;
        vld0 = 1'b1;
        while (rdy0 !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("send0_timeout", 32'(rdy0), 32'd1);
        @(negedge clk);
        waited = n;
    endtask

    task automatic send3(input logic [15:0] w, output int waited);
        int n;
        n = 0;
        din3 = w;
        vld3 = 1'b1;
        while (rdy3 !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("send3_timeout", 32'(rdy3), 32'd1);
        @(negedge clk);
        waited = n;
    endtask

    task automatic drain0();
        int n;
        n = 0;
        while (busy0 !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain0_timeout", 32'(busy0), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic drain3();
        int n;
        n = 0;
        while (busy3 !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain3_timeout", 32'(busy3), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [0:15] exp_bits;
        logic [15:0] exp0[$];
        int          w1, w2, w3;
        int          ferr, mism, bad, idx, guard;

        // 16'hA5C3 sent LSB first: 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1
        exp_bits = 16'b1100_0011_1010_0101;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_dout",  32'(dout0),  32'd0);
        chk("rst_frame", 32'(frame0), 32'd0);
        chk("rst_ready", 32'(rdy0),   32'd1);
        chk("rst_busy",  32'(busy0),  32'd0);
        chk("rst_cnt",   32'(cnt0),   32'd0);
        chk("rst_ready3", 32'(rdy3),  32'd1);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single word, bit order and frame timing
        send0(16'hA5C3, w1);
        vld0 = 1'b0;
        chk("single_ready_low", 32'(rdy0), 32'd0);
        chk("single_busy",      32'(busy0), 32'd1);
        ferr = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("single_bit%0d", i), 32'(dout0), 32'(exp_bits[i]));
            if (frame0 !== 1'b0) ferr++;
        end
        chk("single_frame_early", 32'(ferr), 32'd0);
        @(negedge clk);
        chk("single_frame_hi", 32'(frame0), 32'd1);
        chk("single_dout_idle", 32'(dout0), 32'd0);
        chk("single_cnt", 32'(cnt0), 32'd1);
        @(negedge clk);
        chk("single_frame_lo", 32'(frame0), 32'd0);
        chk("single_busy_lo", 32'(busy0), 32'd0);
        chk("single_rx_n", 32'(rx0.size()), 32'd1);
        if (rx0.size() > 0) chk("single_rx", 32'(rx0[0]), 32'h0000A5C3);

        // Back-to-back, no gap
        rx0.delete();
        ft0.delete();
        send0(16'h0001, w1);
        send0(16'h8000, w2);
        send0(16'hFFFF, w3);
        vld0 = 1'b0;
        chk("b2b_wait2", 32'(w2), 32'd1);
        chk("b2b_wait3", 32'(w3), 32'd15);
        drain0();
        chk("b2b_rx_n", 32'(rx0.size()), 32'd3);
        if (rx0.size() == 3) begin
            chk("b2b_rx0", 32'(rx0[0]), 32'h00000001);
            chk("b2b_rx1", 32'(rx0[1]), 32'h00008000);
            chk("b2b_rx2", 32'(rx0[2]), 32'h0000FFFF);
            chk("b2b_space1", 32'(ft0[1] - ft0[0]), 32'd16);
            chk("b2b_space2", 32'(ft0[2] - ft0[1]), 32'd16);
        end
        chk("b2b_cnt", 32'(cnt0), 32'd4);

        // GAP=3 instance
        send3(16'h1234, w1);
        send3(16'h5678, w2);
        vld3 = 1'b0;
        chk("gap_wait2", 32'(w2), 32'd1);
        drain3();
        chk("gap_rx_n", 32'(rx3.size()), 32'd2);
        if (rx3.size() == 2) begin
            chk("gap_rx0", 32'(rx3[0]), 32'h00001234);
            chk("gap_rx1", 32'(rx3[1]), 32'h00005678);
            chk("gap_space", 32'(ft3[1] - ft3[0]), 32'd19);
            chk("gap_dout_at_frame", 32'(fd3[0]), 32'd0);
        end
        chk("gap_cnt", 32'(cnt3), 32'd2);

        // Asynchronous reset in the middle of a frame
        send0(16'hFFFF, w1);
        vld0 = 1'b0;
        repeat (8) @(negedge clk);
        chk("midrst_bit7", 32'(dout0), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_dout",  32'(dout0),  32'd0);
        chk("midrst_frame", 32'(frame0), 32'd0);
        chk("midrst_ready", 32'(rdy0),   32'd1);
        chk("midrst_cnt",   32'(cnt0),   32'd0);
        chk("midrst_busy",  32'(busy0),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        rx0.delete();
        send0(16'h00FF, w1);
        vld0 = 1'b0;
        drain0();
        chk("postrst_rx_n", 32'(rx0.size()), 32'd1);
        if (rx0.size() > 0) chk("postrst_rx", 32'(rx0[0]), 32'h000000FF);
        chk("postrst_cnt", 32'(cnt0), 32'd1);

        // 257 words: frame_cnt wraps 255 -> 0 -> 1
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        rx0.delete();
        ft0.delete();
        cl0.delete();
        exp0.delete();
        for (int i = 0; i < 257; i++) begin
            exp0.push_back(16'(i * 257) ^ 16'h5A5A);
            send0(exp0[i], w1);
        end
        vld0 = 1'b0;
        drain0();
        chk("wrap_rx_n", 32'(rx0.size()), 32'd257);
        if (cl0.size() == 257) begin
            chk("wrap_cnt254", 32'(cl0[254]), 32'd255);
            chk("wrap_cnt255", 32'(cl0[255]), 32'd0);
            chk("wrap_cnt256", 32'(cl0[256]), 32'd1);
        end
        mism = 0;
        for (int i = 0; i < 257; i++)
            if (i >= rx0.size() || rx0[i] !== exp0[i]) mism++;
        chk("wrap_data", 32'(mism), 32'd0);
        bad = 0;
        for (int i = 1; i < ft0.size(); i++)
            if (ft0[i] - ft0[i-1] != 16) bad++;
        chk("wrap_spacing", 32'(bad), 32'd0);
        chk("wrap_cnt_final", 32'(cnt0), 32'd1);

        // Random valid toggling, 1000 words
        rx0.delete();
        exp0.delete();
        idx = 0;
        guard = 0;
        while (idx < 1000 && guard < 40000) begin
            vld0 = ($urandom_range(0, 3) != 0);
            din0 = 16'($urandom);
            if (vld0 && rdy0) begin
                exp0.push_back(din0);
                idx++;
            end
            @(negedge clk);
            guard++;
        end
        vld0 = 1'b0;
        chk("rand_accepted", 32'(idx), 32'd1000);
        drain0();
        chk("rand_rx_n", 32'(rx0.size()), 32'(exp0.size()));
        mism = 0;
        for (int i = 0; i < exp0.size(); i++)
            if (i >= rx0.size() || rx0[i] !== exp0[i]) mism++;
        chk("rand_data", 32'(mism), 32'd0);
        chk("rand_cnt", 32'(cnt0), 32'd233);
        chk("no_double_frame", 32'(dbl0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
